// File: rtl/uart_pkg.sv
// uart_pkg: constants and helpers shared by the UART receive/transmit blocks.
//   UART_DATA_W        bits per character
//   UART_RXFIFO_DEPTH  entries in the receive buffer
//   uart_clog2()       ceiling log2, used to size FIFO pointers
//   fifo_op_e          per-cycle FIFO operation after qualification
package uart_pkg;

    localparam int unsigned UART_DATA_W       = 8;
    localparam int unsigned UART_RXFIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic int unsigned uart_clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: DEPTH x DATA_W register array, one synchronous write port
// and one asynchronous read port. Shared by the RX and TX FIFOs.
//   clk    clock
//   reset  synchronous active-high; clears every entry to 0
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data, combinational from mem[raddr]
module uart_fifo_ram #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Entries are cleared on reset so a read while empty never returns X.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer between uart_rx and
// uart_reg, with level flags, sticky overrun and a threshold interrupt.
//   clk         clock (PCLK domain)
//   reset       synchronous active-high
//   rx_load     character valid strobe from uart_rx
//   rx_data     character from uart_rx
//   pop         consume head entry
//   rd_data     head entry, valid when empty=0
//   empty/full  count==0 / count==DEPTH
//   count       entries held, 0..DEPTH
//   thresh      interrupt level, 0 disables
//   thresh_irq  level: count>=thresh and thresh!=0
//   irq_pulse   one-cycle pulse on thresh_irq rising
//   overrun     sticky: a character was dropped
//   ovr_clr     clears overrun (a same-cycle set wins)
//   flush       discard all entries; overrides push and pop
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = UART_RXFIFO_DEPTH,
    parameter int unsigned AW     = uart_clog2(DEPTH),
    parameter int unsigned DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_load,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       count,
    input  logic [AW:0]       thresh,
    output logic              thresh_irq,
    output logic              irq_pulse,
    output logic              overrun,
    input  logic              ovr_clr,
    input  logic              flush
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          thresh_irq_q, thresh_irq_d;
    logic          irq_pulse_q, irq_pulse_d;

    logic          empty_w, full_w;
    logic          pop_ok, push_ok, drop;
    logic          ram_we;
    fifo_op_e      op;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == FULL_CNT);

    always_comb begin
        pop_ok  = pop && !empty_w;
        // A valid pop frees the slot the push needs, so a full FIFO still accepts.
        push_ok = rx_load && (!full_w || pop_ok);
        drop    = rx_load && full_w && !pop_ok && !flush;
        op      = fifo_op_e'({pop_ok, push_ok});
        ram_we  = push_ok && !flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            unique case (op)
                FIFO_PUSH: begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                end
                FIFO_POP: begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                end
                FIFO_BOTH: begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                default: ;
            endcase
        end

        overrun_d = drop ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);

        // Evaluated on next-state count so the flag moves with count.
        thresh_irq_d = (thresh != '0) && (count_d >= thresh);
        irq_pulse_d  = thresh_irq_d && !thresh_irq_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overrun_q    <= 1'b0;
            thresh_irq_q <= 1'b0;
            irq_pulse_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overrun_q    <= overrun_d;
            thresh_irq_q <= thresh_irq_d;
            irq_pulse_q  <= irq_pulse_d;
        end
    end

    uart_fifo_ram #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (rx_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign empty      = empty_w;
    assign full       = full_w;
    assign count      = count_q;
    assign overrun    = overrun_q;
    assign thresh_irq = thresh_irq_q;
    assign irq_pulse  = irq_pulse_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_load;
    logic [DW-1:0] rx_data;
    logic          pop;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic [AW:0]   thresh;
    logic          thresh_irq;
    logic          irq_pulse;
    logic          overrun;
    logic          ovr_clr;
    logic          flush;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_load    (rx_load),
        .rx_data    (rx_data),
        .pop        (pop),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .thresh     (thresh),
        .thresh_irq (thresh_irq),
        .irq_pulse  (irq_pulse),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr),
        .flush      (flush)
    );

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned failed = 0;

    // Scoreboard: characters the FIFO should hold, head first.
    logic [DW-1:0] sb[$];
    logic          m_ovr;
    logic          m_irq;
    logic          m_pulse;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ":count"},      32'(count),      32'(sb.size()));
        check({tag, ":empty"},      32'(empty),      32'(sb.size() == 0));
        check({tag, ":full"},       32'(full),       32'(sb.size() == DEPTH));
        check({tag, ":overrun"},    32'(overrun),    32'(m_ovr));
        check({tag, ":thresh_irq"}, 32'(thresh_irq), 32'(m_irq));
        check({tag, ":irq_pulse"},  32'(irq_pulse),  32'(m_pulse));
        if (sb.size() > 0)
            check({tag, ":head"}, 32'(rd_data), 32'(sb[0]));
    endtask

    // One clock of stimulus; the model is advanced, then outputs checked #1 after the edge.
    task automatic cycle(input string tag, input logic ld, input logic [DW-1:0] d,
                         input logic p, input logic fl, input logic clr);
        logic pop_v;
        logic set_ovr;
        logic new_irq;
        rx_load = ld;
        rx_data = d;
        pop     = p;
        flush   = fl;
        ovr_clr = clr;
        pop_v   = p && (sb.size() > 0);
        if (pop_v)
            check({tag, ":pop_data"}, 32'(rd_data), 32'(sb[0]));
        set_ovr = ld && !fl && (sb.size() == DEPTH) && !pop_v;
        if (fl) begin
            sb.delete();
        end else begin
            if (pop_v) void'(sb.pop_front());
            if (ld && !set_ovr) sb.push_back(d);
        end
        m_ovr   = set_ovr ? 1'b1 : (clr ? 1'b0 : m_ovr);
        new_irq = (thresh != 0) && (sb.size() >= int'(thresh));
        m_pulse = new_irq && !m_irq;
        m_irq   = new_irq;
        @(posedge clk);
        #1;
        rx_load = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        ovr_clr = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        rx_load = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        ovr_clr = 1'b0;
        sb.delete();
        m_ovr   = 1'b0;
        m_irq   = 1'b0;
        m_pulse = 1'b0;
        check_state(tag);
        check({tag, ":rd_data"}, 32'(rd_data), 32'h0);
    endtask

    initial begin
        reset   = 1'b1;
        rx_load = 1'b0;
        rx_data = '0;
        pop     = 1'b0;
        flush   = 1'b0;
        ovr_clr = 1'b0;
        thresh  = '0;
        m_ovr   = 1'b0;
        m_irq   = 1'b0;
        m_pulse = 1'b0;
        @(posedge clk);
        do_reset("reset");

        // Single push then pop.
        cycle("push41", 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        check("push41:rd_data", 32'(rd_data), 32'h41);
        cycle("pop41", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("pop41:empty", 32'(empty), 32'h1);

        // Pop while empty is ignored.
        cycle("pop_empty", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Fill, overrun, drain, clear.
        for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        check("fill:full", 32'(full), 32'h1);
        cycle("push_full", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        check("push_full:overrun", 32'(overrun), 32'h1);
        check("push_full:count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("drain:overrun_sticky", 32'(overrun), 32'h1);
        cycle("ovr_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("ovr_clr:overrun", 32'(overrun), 32'h0);

        // Set and clear in the same cycle: set wins.
        for (int i = 0; i < 16; i++) cycle("fill2", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        cycle("set_vs_clr", 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
        check("set_vs_clr:overrun", 32'(overrun), 32'h1);
        cycle("flush_full", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 16; i++) cycle("fill3", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        cycle("both_full", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        check("both_full:count", 32'(count), 32'd16);
        check("both_full:overrun", 32'(overrun), 32'h0);
        for (int i = 0; i < 15; i++) cycle("drain3", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("drain3:last", 32'(rd_data), 32'h55);
        cycle("drain3_last", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Empty with simultaneous push and pop: push only.
        cycle("both_empty", 1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
        check("both_empty:count", 32'(count), 32'd1);
        cycle("both_empty_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Threshold interrupt.
        thresh = 5'd4;
        for (int i = 0; i < 3; i++) cycle("thr_push", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        check("thr3:irq", 32'(thresh_irq), 32'h0);
        cycle("thr_push4", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        check("thr4:irq", 32'(thresh_irq), 32'h1);
        check("thr4:pulse", 32'(irq_pulse), 32'h1);
        cycle("thr_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("thr_idle:pulse", 32'(irq_pulse), 32'h0);
        cycle("thr_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("thr_pop:irq", 32'(thresh_irq), 32'h0);
        thresh = 5'd0;
        for (int i = 0; i < 13; i++) cycle("thr_off", 1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
        check("thr_off:irq", 32'(thresh_irq), 32'h0);
        cycle("thr_flush", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Random traffic across pointer wrap.
        thresh = 5'd6;
        for (int i = 0; i < 100; i++) begin
            cycle("rand", ($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 45),
                  1'b0, 1'b0);
        end
        thresh = 5'd0;

        // Flush with rx_load in the same cycle.
        cycle("pre_flush", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle("five", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        check("five:count", 32'(count), 32'd5);
        cycle("flush_load", 1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        check("flush_load:count", 32'(count), 32'd0);
        check("flush_load:empty", 32'(empty), 32'h1);
        cycle("post_flush", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);

        // Reset mid-traffic.
        thresh = 5'd2;
        cycle("pre_rst", 1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
        cycle("pre_rst2", 1'b1, 8'h79, 1'b0, 1'b0, 1'b0);
        rx_load = 1'b1;
        rx_data = 8'h99;
        pop     = 1'b1;
        do_reset("mid_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
